mem_port_arbiter: RTL and testbench

- Sits in front of the single-port word memory (`Mem`, 4 byte-lane selects, registered read data) and shares it between two requesters.
  - m0: instruction fetch.
  - m1: load/store unit.
- Per accepted request it does three jobs:
  - Round-robin arbitration.
  - Byte-address to word-index/byte-lane translation, with write-data lane replication.
  - Alignment checking.
- It also returns load data, lane-extracted and sign/zero-extended, one cycle after acceptance.
- Sustains one access per cycle.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester front end for a single-port word memory with byte-lane selects.
// Each cycle it picks one winner (round-robin on ties) and turns the byte address
// into a word index and lane selects. It flags misaligned or illegal-size accesses.
// Load data comes back one cycle after the grant, with the lanes extracted and
// the value sign- or zero-extended.
module mem_port_arbiter #(
    parameter int MEM_ADDR_BITS = 20,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       clr_n,

    input  logic                       m0_req,
    input  logic                       m0_we,
    input  logic [MEM_ADDR_BITS+1:0]   m0_addr,
    input  logic [1:0]                 m0_size,
    input  logic                       m0_unsigned,
    input  logic [MEM_DATA_BITS-1:0]   m0_wdata,
    output logic                       m0_gnt,
    output logic                       m0_rvalid,
    output logic [MEM_DATA_BITS-1:0]   m0_rdata,
    output logic                       m0_err,

    input  logic                       m1_req,
    input  logic                       m1_we,
    input  logic [MEM_ADDR_BITS+1:0]   m1_addr,
    input  logic [1:0]                 m1_size,
    input  logic                       m1_unsigned,
    input  logic [MEM_DATA_BITS-1:0]   m1_wdata,
    output logic                       m1_gnt,
    output logic                       m1_rvalid,
    output logic [MEM_DATA_BITS-1:0]   m1_rdata,
    output logic                       m1_err,

    output logic [MEM_ADDR_BITS-1:0]   mem_addr,
    output logic [MEM_DATA_BITS-1:0]   mem_data_in,
    output logic [3:0]                 mem_sel,
    output logic                       mem_str,
    output logic                       mem_ld,
    input  logic [MEM_DATA_BITS-1:0]   mem_data_out
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // last_gnt_q = 1 means m1 was granted most recently, so m0 wins the next tie.
    logic                     last_gnt_q, last_gnt_d;

    // Pending response, captured at the grant edge.
    logic                     pend_valid_q, pend_valid_d;
    logic                     pend_owner_q, pend_owner_d;
    logic                     pend_we_q,    pend_we_d;
    logic [1:0]               pend_size_q,  pend_size_d;
    logic [1:0]               pend_off_q,   pend_off_d;
    logic                     pend_uns_q,   pend_uns_d;
    logic                     pend_err_q,   pend_err_d;

    logic                     gnt0, gnt1, any_gnt;
    logic                     sel_we, sel_uns, legal;
    logic [MEM_ADDR_BITS+1:0] sel_addr;
    logic [1:0]               sel_size, sel_off;
    logic [MEM_DATA_BITS-1:0] sel_wdata;
    logic [MEM_DATA_BITS-1:0] shifted, resp_data;

    // Round-robin pick. Grants are held off while reset is asserted so that
    // nothing reaches the memory during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (clr_n) begin
            if (m0_req && m1_req) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;

    assign sel_we    = gnt1 ? m1_we       : m0_we;
    assign sel_addr  = gnt1 ? m1_addr     : m0_addr;
    assign sel_size  = gnt1 ? m1_size     : m0_size;
    assign sel_uns   = gnt1 ? m1_unsigned : m0_unsigned;
    assign sel_wdata = gnt1 ? m1_wdata    : m0_wdata;
    assign sel_off   = sel_addr[1:0];

    // Alignment check; size 11 is never legal.
    always_comb begin
        legal = 1'b0;
        case (sel_size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~sel_off[0];
            SZ_WORD: legal = (sel_off == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Memory-side drive: the memory bus stays all-zero unless there is a legal grant.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_sel     = 4'b0000;
        mem_str     = 1'b0;
        mem_ld      = 1'b0;
        if (any_gnt && legal) begin
            mem_addr = sel_addr[MEM_ADDR_BITS+1:2];
            mem_str  = sel_we;
            mem_ld   = ~sel_we;
            case (sel_size)
                SZ_BYTE: begin
                    mem_sel     = 4'b0001 << sel_off;
                    mem_data_in = {4{sel_wdata[7:0]}};
                end
                SZ_HALF: begin
                    mem_sel     = sel_off[1] ? 4'b1100 : 4'b0011;
                    mem_data_in = {2{sel_wdata[15:0]}};
                end
                default: begin
                    mem_sel     = 4'b1111;
                    mem_data_in = sel_wdata;
                end
            endcase
        end
    end

    // Next state: remember the winner and capture the response context.
    always_comb begin
        last_gnt_d   = any_gnt ? gnt1 : last_gnt_q;
        pend_valid_d = any_gnt;
        pend_owner_d = gnt1;
        pend_we_d    = sel_we;
        pend_size_d  = sel_size;
        pend_off_d   = sel_off;
        pend_uns_d   = sel_uns;
        pend_err_d   = ~legal;
    end

    // State registers; an in-flight response is dropped on reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_gnt_q   <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_size_q  <= 2'b00;
            pend_off_q   <= 2'b00;
            pend_uns_q   <= 1'b0;
            pend_err_q   <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            pend_valid_q <= pend_valid_d;
            if (any_gnt) begin
                pend_owner_q <= pend_owner_d;
                pend_we_q    <= pend_we_d;
                pend_size_q  <= pend_size_d;
                pend_off_q   <= pend_off_d;
                pend_uns_q   <= pend_uns_d;
                pend_err_q   <= pend_err_d;
            end
        end
    end

    // Lane extraction and extension of the registered memory word.
    always_comb begin
        shifted   = mem_data_out >> {pend_off_q, 3'b000};
        resp_data = '0;
        if (pend_valid_q && !pend_we_q && !pend_err_q) begin
            case (pend_size_q)
                SZ_BYTE: resp_data = pend_uns_q ? {24'b0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
                SZ_HALF: resp_data = pend_uns_q ? {16'b0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
                default: resp_data = shifted;
            endcase
        end
    end

    // Route the response to its owner only.
    always_comb begin
        m0_rvalid = pend_valid_q & ~pend_owner_q;
        m1_rvalid = pend_valid_q &  pend_owner_q;
        m0_err    = m0_rvalid & pend_err_q;
        m1_err    = m1_rvalid & pend_err_q;
        m0_rdata  = m0_rvalid ? resp_data : '0;
        m1_rdata  = m1_rvalid ? resp_data : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural word memory.
module tb_mem_port_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          m0_req, m0_we, m0_unsigned;
    logic [AW+1:0] m0_addr;
    logic [1:0]    m0_size;
    logic [31:0]   m0_wdata;
    logic          m0_gnt, m0_rvalid, m0_err;
    logic [31:0]   m0_rdata;
    logic          m1_req, m1_we, m1_unsigned;
    logic [AW+1:0] m1_addr;
    logic [1:0]    m1_size;
    logic [31:0]   m1_wdata;
    logic          m1_gnt, m1_rvalid, m1_err;
    logic [31:0]   m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in, mem_data_out;
    logic [3:0]    mem_sel;
    logic          mem_str, mem_ld;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(32)) dut (
        .clk(clk), .clr_n(clr_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_unsigned(m0_unsigned), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_unsigned(m1_unsigned), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_sel(mem_sel),
        .mem_str(mem_str), .mem_ld(mem_ld), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Word memory: store commits at the edge, read data registered with
    // unselected lanes zeroed.
    logic [31:0] mem_q [0:15];
    logic [31:0] rd_q;
    assign mem_data_out = rd_q;

    always @(posedge clk) begin
        if (mem_str) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) mem_q[mem_addr[3:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
        if (mem_ld)
            rd_q <= mem_q[mem_addr[3:0]] & {{8{mem_sel[3]}}, {8{mem_sel[2]}},
                                             {8{mem_sel[1]}}, {8{mem_sel[0]}}};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic [AW+1:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_addr = addr; m0_size = size;
        m0_unsigned = uns; m0_wdata = wd;
    endtask

    task automatic set1(input logic req, input logic we, input logic [AW+1:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_addr = addr; m1_size = size;
        m1_unsigned = uns; m1_wdata = wd;
    endtask

    initial begin
        clr_n = 1'b0;
        set0(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        set1(1'b0, 1'b0, 22'h0,  2'b00, 1'b0, 32'h0);
        #3;
        check("rst_gnt0",   32'(m0_gnt),    32'h0);
        check("rst_ld",     32'(mem_ld),    32'h0);
        check("rst_rvalid", 32'(m0_rvalid), 32'h0);
        check("rst_rdata",  m0_rdata,       32'h0);
        m0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;

        // m1 word store 0xDEADBEEF at 0x10
        set1(1'b1, 1'b1, 22'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        #1;
        check("st_gnt1", 32'(m1_gnt),  32'h1);
        check("st_gnt0", 32'(m0_gnt),  32'h0);
        check("st_addr", 32'(mem_addr), 32'h4);
        check("st_sel",  32'(mem_sel), 32'hF);
        check("st_str",  32'(mem_str), 32'h1);
        check("st_ld",   32'(mem_ld),  32'h0);
        check("st_din",  mem_data_in,  32'hDEADBEEF);

        // m0 signed byte load at 0x13
        tick();
        set1(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        set0(1'b1, 1'b0, 22'h13, 2'b00, 1'b0, 32'h0);
        #1;
        check("st_rv1",   32'(m1_rvalid), 32'h1);
        check("st_err1",  32'(m1_err),    32'h0);
        check("st_rd1",   m1_rdata,       32'h0);
        check("st_rv0",   32'(m0_rvalid), 32'h0);
        check("lb_gnt0",  32'(m0_gnt),    32'h1);
        check("lb_sel",   32'(mem_sel),   32'h8);
        check("lb_ld",    32'(mem_ld),    32'h1);

        // m0 unsigned byte load at 0x13
        tick();
        set0(1'b1, 1'b0, 22'h13, 2'b00, 1'b1, 32'h0);
        #1;
        check("lb_rv0",   32'(m0_rvalid), 32'h1);
        check("lb_s",     m0_rdata,       32'hFFFFFFDE);
        check("lbu_gnt0", 32'(m0_gnt),    32'h1);

        // m1 signed half load at 0x12
        tick();
        set0(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        set1(1'b1, 1'b0, 22'h12, 2'b01, 1'b0, 32'h0);
        #1;
        check("lbu_rv0", 32'(m0_rvalid), 32'h1);
        check("lbu_u",   m0_rdata,       32'h000000DE);
        check("lh_sel",  32'(mem_sel),   32'hC);

        // m1 unsigned half load at 0x12
        tick();
        set1(1'b1, 1'b0, 22'h12, 2'b01, 1'b1, 32'h0);
        #1;
        check("lh_s",  m1_rdata,       32'hFFFFDEAD);
        check("lh_r0", 32'(m0_rvalid), 32'h0);

        // m1 half store 0x1234 at 0x10
        tick();
        set1(1'b1, 1'b1, 22'h10, 2'b01, 1'b0, 32'hFFFF1234);
        #1;
        check("lhu_u",  m1_rdata,      32'h0000DEAD);
        check("sh_sel", 32'(mem_sel),  32'h3);
        check("sh_din", mem_data_in,   32'h12341234);
        check("sh_str", 32'(mem_str),  32'h1);

        // m0 word load at 0x10 right after the store
        tick();
        set1(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        set0(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        #1;
        check("sh_rv1",  32'(m1_rvalid), 32'h1);
        check("sh_rd1",  m1_rdata,       32'h0);
        check("lw_gnt0", 32'(m0_gnt),    32'h1);

        tick();
        set0(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        #1;
        check("raw_rv0", 32'(m0_rvalid), 32'h1);
        check("raw_rd0", m0_rdata,       32'hDEAD1234);
        check("raw_rv1", 32'(m1_rvalid), 32'h0);

        // Reset, then both requesters held for 4 cycles: m0, m1, m0, m1
        tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        set0(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        set1(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt0", 32'(m0_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_gnt1", 32'(m1_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
            if (i > 0) begin
                check("rr_rv0", 32'(m0_rvalid), (i % 2 == 1) ? 32'h1 : 32'h0);
                check("rr_rv1", 32'(m1_rvalid), (i % 2 == 0) ? 32'h1 : 32'h0);
                check("rr_rd",  m0_rdata | m1_rdata, 32'hDEAD1234);
            end
            tick();
        end
        set0(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        set1(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        #1;
        check("rr_last1", 32'(m1_rvalid), 32'h1);
        check("rr_last0", 32'(m0_rvalid), 32'h0);
        check("rr_rdz0",  m0_rdata,       32'h0);

        // Misaligned word load at 0x11
        tick();
        set0(1'b1, 1'b0, 22'h11, 2'b10, 1'b0, 32'h0);
        #1;
        check("mis_gnt",  32'(m0_gnt),   32'h1);
        check("mis_ld",   32'(mem_ld),   32'h0);
        check("mis_sel",  32'(mem_sel),  32'h0);
        check("mis_addr", 32'(mem_addr), 32'h0);

        // Illegal size 11 store at 0x10
        tick();
        set0(1'b1, 1'b1, 22'h10, 2'b11, 1'b0, 32'hCAFEF00D);
        #1;
        check("mis_rv",  32'(m0_rvalid), 32'h1);
        check("mis_err", 32'(m0_err),    32'h1);
        check("mis_rd",  m0_rdata,       32'h0);
        check("ill_str", 32'(mem_str),   32'h0);
        check("ill_din", mem_data_in,    32'h0);

        tick();
        set0(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        #1;
        check("ill_rv",  32'(m0_rvalid), 32'h1);
        check("ill_err", 32'(m0_err),    32'h1);
        check("ill_rd",  m0_rdata,       32'h0);

        // Reset during an m0 response, then the next tie must go to m0
        tick();
        set0(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        tick();
        set0(1'b0, 1'b0, 22'h0, 2'b00, 1'b0, 32'h0);
        #1;
        check("cr_rv_pre", 32'(m0_rvalid), 32'h1);
        clr_n = 1'b0;
        #1;
        check("cr_rv",  32'(m0_rvalid), 32'h0);
        check("cr_rd",  m0_rdata,       32'h0);
        tick();
        clr_n = 1'b1;
        set0(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        set1(1'b1, 1'b0, 22'h10, 2'b10, 1'b0, 32'h0);
        #1;
        check("cr_tie0", 32'(m0_gnt), 32'h1);
        check("cr_tie1", 32'(m1_gnt), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
